// File: rtl/player_pkg.sv
// Shared types, entity codes and field layout for the player controller.
package player_pkg;

    localparam logic [3:0] ENT_PLAYER = 4'b0010;
    localparam logic [3:0] ENT_SWORD  = 4'b0001;
    localparam logic [3:0] ENT_HIDDEN = 4'b1111;

    typedef enum logic [1:0] {
        ORIENT_UP    = 2'b00,
        ORIENT_RIGHT = 2'b01,
        ORIENT_DOWN  = 2'b10,
        ORIENT_LEFT  = 2'b11
    } orient_e;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        DEAD
    } state_e;

    localparam int ENT_W      = 14;
    localparam int ID_LSB     = 10;
    localparam int ORIENT_LSB = 8;
    localparam int X_LSB      = 4;
    localparam int Y_LSB      = 0;

    function automatic logic [ENT_W-1:0] pack_entity(input logic [3:0] id, input logic [1:0] o,
                                                     input logic [3:0] x, input logic [3:0] y);
        logic [ENT_W-1:0] e;
        e = '0;
        e[ID_LSB +: 4]     = id;
        e[ORIENT_LSB +: 2] = o;
        e[X_LSB +: 4]      = x;
        e[Y_LSB +: 4]      = y;
        return e;
    endfunction

    // Neighbouring tile in direction o, as {x[4:0], y[4:0]}; the extra bit exposes wrap below 0.
    function automatic logic [9:0] step_tile(input logic [3:0] x, input logic [3:0] y,
                                             input logic [1:0] o);
        logic [4:0] tx;
        logic [4:0] ty;
        tx = {1'b0, x};
        ty = {1'b0, y};
        case (o)
            ORIENT_UP:    ty = ty - 5'd1;
            ORIENT_RIGHT: tx = tx + 5'd1;
            ORIENT_DOWN:  ty = ty + 5'd1;
            default:      tx = tx - 5'd1;
        endcase
        return {tx, ty};
    endfunction

endpackage

// File: rtl/player_controller_counter.sv
// Loadable down counter that saturates at zero and reports a zero flag.
module tick_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/player_controller.sv
// Player movement, sword attack, damage and death, all paced by frame_tick.
module player_controller
    import player_pkg::*;
#(
    parameter int X_MIN         = 1,
    parameter int X_MAX         = 14,
    parameter int Y_MIN         = 2,
    parameter int Y_MAX         = 10,
    parameter int START_X       = 7,
    parameter int START_Y       = 5,
    parameter int MAX_HEALTH    = 3,
    parameter int HEALTH_W      = 2,
    parameter int MOVE_COOLDOWN = 2,
    parameter int ATTACK_FRAMES = 4,
    parameter int INVULN_FRAMES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                A,
    input  logic                B,
    input  logic                up,
    input  logic                down,
    input  logic                left,
    input  logic                right,
    input  logic                hit,
    output logic [13:0]         player,
    output logic [13:0]         sword,
    output logic [HEALTH_W-1:0] player_health,
    output logic                invulnerable,
    output logic                game_over
);

    localparam logic [13:0] SWORD_HIDDEN = {ENT_HIDDEN, ORIENT_RIGHT, 4'd0, 4'd0};

    state_e              state_q, state_d;
    logic [1:0]          orient_q, orient_d;
    logic [3:0]          x_q, x_d, y_q, y_d;
    logic [13:0]         sword_q, sword_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic                atk_prev_q, atk_prev_d;

    logic move_load, move_en, move_zero;
    logic atk_load, atk_en, atk_zero;
    logic inv_load, inv_en, inv_zero;
    logic atk_edge, dir_valid;
    logic [1:0] dir_code;
    logic [9:0] front, target;

    function automatic logic in_bounds(input logic [9:0] t);
        return (t[9:5] >= 5'(X_MIN)) && (t[9:5] <= 5'(X_MAX)) &&
               (t[4:0] >= 5'(Y_MIN)) && (t[4:0] <= 5'(Y_MAX));
    endfunction

    tick_down_counter #(.W(CNT_W)) u_move_cnt (
        .clk(clk), .rst(reset), .load(move_load), .load_value(CNT_W'(MOVE_COOLDOWN)),
        .enable(move_en), .zero(move_zero)
    );

    tick_down_counter #(.W(CNT_W)) u_atk_cnt (
        .clk(clk), .rst(reset), .load(atk_load), .load_value(CNT_W'(ATTACK_FRAMES - 1)),
        .enable(atk_en), .zero(atk_zero)
    );

    tick_down_counter #(.W(CNT_W)) u_inv_cnt (
        .clk(clk), .rst(reset), .load(inv_load), .load_value(CNT_W'(INVULN_FRAMES)),
        .enable(inv_en), .zero(inv_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            orient_q   <= ORIENT_RIGHT;
            x_q        <= 4'(START_X);
            y_q        <= 4'(START_Y);
            sword_q    <= SWORD_HIDDEN;
            health_q   <= HEALTH_W'(MAX_HEALTH);
            atk_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            orient_q   <= orient_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sword_q    <= sword_d;
            health_q   <= health_d;
            atk_prev_q <= atk_prev_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        orient_d   = orient_q;
        x_d        = x_q;
        y_d        = y_q;
        sword_d    = sword_q;
        health_d   = health_q;
        atk_prev_d = atk_prev_q;
        move_load  = 1'b0;
        move_en    = 1'b0;
        atk_load   = 1'b0;
        atk_en     = 1'b0;
        inv_load   = 1'b0;
        inv_en     = 1'b0;

        dir_valid = $onehot({up, down, left, right});
        if (up)        dir_code = ORIENT_UP;
        else if (right) dir_code = ORIENT_RIGHT;
        else if (down)  dir_code = ORIENT_DOWN;
        else            dir_code = ORIENT_LEFT;

        atk_edge = (A | B) & ~atk_prev_q;
        front    = step_tile(x_q, y_q, orient_q);
        target   = step_tile(x_q, y_q, dir_code);

        if (frame_tick) begin
            atk_prev_d = A | B;
            case (state_q)
                IDLE: begin
                    if (atk_edge && in_bounds(front)) begin
                        state_d  = ATTACK;
                        sword_d  = pack_entity(ENT_SWORD, orient_q, front[8:5], front[3:0]);
                        atk_load = 1'b1;
                        move_en  = 1'b1;
                    end else begin
                        if (dir_valid) begin
                            orient_d = dir_code;
                            if (move_zero && in_bounds(target)) begin
                                x_d       = target[8:5];
                                y_d       = target[3:0];
                                move_load = 1'b1;
                            end
                        end
                        move_en = !move_load;
                    end
                end
                ATTACK: begin
                    atk_en  = 1'b1;
                    move_en = 1'b1;
                    if (atk_zero) begin
                        state_d = IDLE;
                        sword_d = SWORD_HIDDEN;
                    end
                end
                default: ;
            endcase

            // Damage is resolved last so a fatal hit overrides the same-tick move or attack.
            if (state_q != DEAD) begin
                inv_en = 1'b1;
                if (hit && inv_zero && health_q != '0) begin
                    health_d = health_q - HEALTH_W'(1);
                    inv_load = 1'b1;
                    if (health_q == HEALTH_W'(1)) begin
                        state_d  = DEAD;
                        sword_d  = SWORD_HIDDEN;
                        orient_d = orient_q;
                        x_d      = x_q;
                        y_d      = y_q;
                    end
                end
            end
        end
    end

    assign player        = pack_entity(ENT_PLAYER, orient_q, x_q, y_q);
    assign sword         = sword_q;
    assign player_health = health_q;
    assign invulnerable  = !inv_zero && (state_q != DEAD);
    assign game_over     = (state_q == DEAD);

endmodule

// File: tb/tb_player_controller.sv
// Self-checking bench: constant vector table, directed corner sequences, random run vs model.
module tb_player_controller;

    localparam int X_MIN = 1, X_MAX = 14, Y_MIN = 2, Y_MAX = 10;
    localparam int START_X = 7, START_Y = 5, MAX_HEALTH = 3, HEALTH_W = 2;
    localparam int MOVE_COOLDOWN = 2, ATTACK_FRAMES = 4, INVULN_FRAMES = 8, CNT_W = 4;

    logic clk = 0, reset = 0, frame_tick = 0;
    logic A = 0, B = 0, up = 0, down = 0, left = 0, right = 0, hit = 0;
    logic [13:0] player, sword;
    logic [HEALTH_W-1:0] player_health;
    logic invulnerable, game_over;

    int checks = 0;
    int errors = 0;

    player_controller #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .START_X(START_X), .START_Y(START_Y), .MAX_HEALTH(MAX_HEALTH), .HEALTH_W(HEALTH_W),
        .MOVE_COOLDOWN(MOVE_COOLDOWN), .ATTACK_FRAMES(ATTACK_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .A(A), .B(B),
        .up(up), .down(down), .left(left), .right(right), .hit(hit),
        .player(player), .sword(sword), .player_health(player_health),
        .invulnerable(invulnerable), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ent(input logic [3:0] id, input logic [1:0] o,
                                        input int x, input int y);
        logic [3:0] xx, yy;
        xx = x[3:0];
        yy = y[3:0];
        return {id, o, xx, yy};
    endfunction

    logic [13:0] hidden;
    initial hidden = ent(4'hF, 2'b01, 0, 0);

    // Reference model: game rules in terms of positions and remaining frame counts.
    int  m_x, m_y, m_o, m_health, m_cool, m_inv, m_sword_left;
    bit  m_dead, m_prev;
    logic [13:0] m_sword;

    function automatic bit inb(input int x, input int y);
        return x >= X_MIN && x <= X_MAX && y >= Y_MIN && y <= Y_MAX;
    endfunction

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_o = 1; m_health = MAX_HEALTH;
        m_cool = 0; m_inv = 0; m_sword_left = 0; m_dead = 0; m_prev = 0;
        m_sword = ent(4'hF, 2'b01, 0, 0);
    endtask

    task automatic model_tick(input bit a, input bit b, input bit u, input bit d,
                              input bit l, input bit r, input bit h);
        bit edge_now, moved;
        int dx[4], dy[4], nd, tx, ty;
        dx = '{0, 1, 0, -1};
        dy = '{-1, 0, 1, 0};
        edge_now = (a || b) && !m_prev;
        m_prev = a || b;
        if (m_dead) return;
        if (h && m_inv == 0) begin
            m_health = m_health - 1;
            m_inv = INVULN_FRAMES;
        end else if (m_inv > 0) m_inv = m_inv - 1;
        if (m_health == 0) begin
            m_dead = 1;
            m_sword = ent(4'hF, 2'b01, 0, 0);
            return;
        end
        moved = 0;
        if (m_sword_left > 0) begin
            m_sword_left = m_sword_left - 1;
            if (m_sword_left == 0) m_sword = ent(4'hF, 2'b01, 0, 0);
        end else if (edge_now && inb(m_x + dx[m_o], m_y + dy[m_o])) begin
            m_sword_left = ATTACK_FRAMES;
            m_sword = ent(4'h1, 2'(m_o), m_x + dx[m_o], m_y + dy[m_o]);
        end else if (int'(u) + int'(d) + int'(l) + int'(r) == 1) begin
            nd = u ? 0 : r ? 1 : d ? 2 : 3;
            m_o = nd;
            tx = m_x + dx[nd];
            ty = m_y + dy[nd];
            if (m_cool == 0 && inb(tx, ty)) begin
                m_x = tx; m_y = ty; m_cool = MOVE_COOLDOWN; moved = 1;
            end
        end
        if (!moved && m_cool > 0) m_cool = m_cool - 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".player"}, 32'(player), 32'(ent(4'h2, 2'(m_o), m_x, m_y)));
        chk({tag, ".sword"}, 32'(sword), 32'(m_sword));
        chk({tag, ".health"}, 32'(player_health), 32'(m_health));
        chk({tag, ".invuln"}, 32'(invulnerable), 32'(!m_dead && m_inv > 0));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_dead));
    endtask

    task automatic apply(input bit t, input bit a, input bit b, input bit u, input bit d,
                         input bit l, input bit r, input bit h);
        @(negedge clk);
        frame_tick = t; A = a; B = b; up = u; down = d; left = l; right = r; hit = h;
        @(posedge clk);
        if (t) model_tick(a, b, u, d, l, r, h);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; frame_tick = 0; A = 0; B = 0; up = 0; down = 0; left = 0; right = 0; hit = 0;
        @(negedge clk);
        reset = 0;
        model_reset();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".player"}, 32'(player), 32'(ent(4'h2, 2'b01, START_X, START_Y)));
        chk({tag, ".sword"}, 32'(sword), 32'(hidden));
        chk({tag, ".health"}, 32'(player_health), MAX_HEALTH);
        chk({tag, ".invuln"}, 32'(invulnerable), 0);
        chk({tag, ".game_over"}, 32'(game_over), 0);
    endtask

    typedef struct {
        bit t, a, b, u, d, l, r, h;
        logic [13:0] exp_player, exp_sword;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // {tick, A, B, up, down, left, right, hit} -> expected player / sword, from reset at (7,5)
        vecs[0]  = '{1,1,0,0,0,0,0,0, ent(2,1,7,5), ent(1,1,8,5)};
        vecs[1]  = '{1,1,0,0,0,0,1,0, ent(2,1,7,5), ent(1,1,8,5)};
        vecs[2]  = '{1,1,0,0,0,0,1,0, ent(2,1,7,5), ent(1,1,8,5)};
        vecs[3]  = '{1,1,0,0,0,0,1,0, ent(2,1,7,5), ent(1,1,8,5)};
        vecs[4]  = '{1,1,0,0,0,0,0,0, ent(2,1,7,5), ent(15,1,0,0)};
        vecs[5]  = '{1,1,0,0,0,0,1,0, ent(2,1,8,5), ent(15,1,0,0)};
        vecs[6]  = '{1,0,0,0,0,0,1,0, ent(2,1,8,5), ent(15,1,0,0)};
        vecs[7]  = '{0,0,0,0,0,0,1,0, ent(2,1,8,5), ent(15,1,0,0)};
        vecs[8]  = '{1,0,0,0,0,0,1,0, ent(2,1,8,5), ent(15,1,0,0)};
        vecs[9]  = '{1,0,0,0,0,0,1,0, ent(2,1,9,5), ent(15,1,0,0)};
        vecs[10] = '{1,0,0,1,0,1,0,0, ent(2,1,9,5), ent(15,1,0,0)};
        vecs[11] = '{1,0,0,0,0,1,0,0, ent(2,3,9,5), ent(15,1,0,0)};
        vecs[12] = '{1,0,0,0,1,0,0,0, ent(2,2,9,6), ent(15,1,0,0)};
        vecs[13] = '{1,0,1,0,0,0,0,0, ent(2,2,9,6), ent(1,2,9,7)};

        reset = 1;
        #12;
        reset = 0;
        model_reset();
        #1;
        check_reset_values("reset");

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].d,
                  vecs[i].l, vecs[i].r, vecs[i].h);
            chk($sformatf("vec%0d.player", i), 32'(player), 32'(vecs[i].exp_player));
            chk($sformatf("vec%0d.sword", i), 32'(sword), 32'(vecs[i].exp_sword));
            chk($sformatf("vec%0d.health", i), 32'(player_health), MAX_HEALTH);
        end

        // Right edge: attack ignored facing out of the arena, movement still proceeds.
        do_reset();
        for (int i = 0; i < 24; i++) apply(1,0,0,0,0,0,1,0);
        chk("redge.walk", 32'(player), 32'(ent(2,1,14,5)));
        apply(1,0,1,0,0,0,0,0);
        chk("redge.noatk.sword", 32'(sword), 32'(hidden));
        chk("redge.noatk.player", 32'(player), 32'(ent(2,1,14,5)));
        apply(1,0,0,0,0,0,0,0);
        apply(1,0,1,1,0,0,0,0);
        chk("redge.move.player", 32'(player), 32'(ent(2,0,14,4)));
        chk("redge.move.sword", 32'(sword), 32'(hidden));

        // Left edge: blocked move, out-of-bounds attack, ambiguous direction.
        do_reset();
        for (int i = 0; i < 20; i++) apply(1,0,0,0,0,1,0,0);
        chk("ledge.walk", 32'(player), 32'(ent(2,3,1,5)));
        apply(1,1,0,0,0,0,0,0);
        chk("ledge.noatk", 32'(sword), 32'(hidden));
        apply(1,0,0,1,0,1,0,0);
        chk("ledge.multi", 32'(player), 32'(ent(2,3,1,5)));

        // Sustained hit: invulnerability windows, death, frozen afterwards.
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            apply(1,0,0,0,0,0,0,1);
            if (t == 1) begin
                chk("hit.t1.health", 32'(player_health), 2);
                chk("hit.t1.invuln", 32'(invulnerable), 1);
            end
            if (t == 9)  chk("hit.t9.health", 32'(player_health), 2);
            if (t == 10) chk("hit.t10.health", 32'(player_health), 1);
            if (t == 18) chk("hit.t18.health", 32'(player_health), 1);
            if (t == 19) begin
                chk("hit.t19.health", 32'(player_health), 0);
                chk("hit.t19.game_over", 32'(game_over), 1);
                chk("hit.t19.invuln", 32'(invulnerable), 0);
            end
        end
        for (int i = 0; i < 5; i++) apply(1, i[0], 0, 0, 0, 0, 1, 1);
        chk("dead.player", 32'(player), 32'(ent(2,1,7,5)));
        chk("dead.sword", 32'(sword), 32'(hidden));
        chk("dead.game_over", 32'(game_over), 1);
        chk("dead.health", 32'(player_health), 0);

        // Asynchronous reset between clock edges during an attack.
        do_reset();
        apply(1,1,0,0,0,0,0,0);
        chk("areset.pre.sword", 32'(sword), 32'(ent(1,1,8,5)));
        #2;
        reset = 1;
        #1;
        check_reset_values("areset");
        @(negedge clk);
        reset = 0;
        model_reset();

        // Random stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            bit u, d, l, r;
            if (i % 250 == 0) do_reset();
            sel = $urandom_range(0, 5);
            u = (sel == 0); r = (sel == 1); d = (sel == 2); l = (sel == 3);
            if (sel == 5) {u, d, l, r} = 4'($urandom);
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  u, d, l, r, $urandom_range(0, 15) == 0);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
